pc_sequencer: RTL

Parametrised program-counter sequencer for the MIPS core. It holds the fetch address and boots to a programmable start address. Each cycle it selects sequential, branch, jump or restart as the next address, honours a pipeline stall, and raises a sticky finish flag once the PC reaches the end-of-program bound. The instruction-memory address comes from this block. A retired-instruction counter feeds the testbench and debug logic.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_next_mux.sv | 39 +++
 rtl/pc_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_DONE = 2'd2
    } pc_state_e;

    localparam logic [1:0] SEL_SEQ     = 2'd0;
    localparam logic [1:0] SEL_BRANCH  = 2'd1;
    localparam logic [1:0] SEL_JUMP    = 2'd2;
    localparam logic [1:0] SEL_RESTART = 2'd3;

    localparam logic [31:0] DEF_START_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_END_ADDR   = 32'h0000_0100;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection, incrementer and redirect alignment check.
// Optional PC_ALIGN_CHECK_EN: flag misaligned branch/jump targets instead of silently masking them.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                INC        = 4
) (
    input  logic [ADDR_W-1:0] address,
    input  logic [1:0]        next_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc_plus_inc,
    output logic [ADDR_W-1:0] next_addr,
    output logic              misaligned
);

    localparam int                ALIGN_BITS = (INC > 1) ? $clog2(INC) : 0;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [ADDR_W-1:0] target;

    always_comb begin
        target      = (next_sel == SEL_JUMP) ? jump_target : branch_target;
        pc_plus_inc = address + ADDR_W'(INC);
        case (next_sel)
            SEL_SEQ:              next_addr = pc_plus_inc;
            SEL_BRANCH, SEL_JUMP: next_addr = target & ~ALIGN_MASK;
            default:              next_addr = START_ADDR;
        endcase
`ifdef PC_ALIGN_CHECK_EN
        misaligned = ((next_sel == SEL_BRANCH) || (next_sel == SEL_JUMP)) && (|(target & ALIGN_MASK));
`else
        misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/DONE FSM, fetch PC register and retired-instruction counter.
// Optional PC_ALIGN_CHECK_EN: misaligned redirects trap into DONE with align_err set.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEF_END_ADDR),
    parameter int                INC        = 4,
    parameter int                CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic [1:0]        next_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] pc_plus_inc,
    output logic              fetch_valid,
    output logic              pfinish,
    output logic [CNT_W-1:0]  instr_count,
    output logic              align_err
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_d, next_addr;
    logic              pfinish_d, retire, misaligned, at_end;

    pc_next_mux #(.ADDR_W(ADDR_W), .START_ADDR(START_ADDR), .INC(INC)) u_mux (
        .address       (address),
        .next_sel      (next_sel),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .pc_plus_inc   (pc_plus_inc),
        .next_addr     (next_addr),
        .misaligned    (misaligned)
    );

    assign at_end      = (address >= END_ADDR);
    assign fetch_valid = (state_q == PC_RUN) && !at_end;

    always_comb begin
        state_d   = state_q;
        addr_d    = address;
        pfinish_d = pfinish;
        retire    = 1'b0;
        case (state_q)
            PC_BOOT: if (start) state_d = PC_RUN;
            PC_RUN: begin
                // End-of-program wins over stall so finish is never delayed.
                if (at_end) begin
                    state_d   = PC_DONE;
                    pfinish_d = 1'b1;
                end else if (!stall) begin
                    if (misaligned) begin
                        state_d   = PC_DONE;
                        pfinish_d = 1'b1;
                    end else begin
                        addr_d = next_addr;
                        retire = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PC_BOOT;
            address     <= START_ADDR;
            pfinish     <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            address <= addr_d;
            pfinish <= pfinish_d;
            if (retire && (instr_count != {CNT_W{1'b1}}))
                instr_count <= instr_count + CNT_W'(1);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic align_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            align_q <= 1'b0;
        else if ((state_q == PC_RUN) && !at_end && !stall && misaligned)
            align_q <= 1'b1;
    end
    assign align_err = align_q;
`else
    assign align_err = 1'b0;
`endif

endmodule
